// File: rtl/rs_encoder_serial.sv
// rs_encoder_serial: systematic RS(15,9) encoder over GF(16), poly x^4+x+1.
// LFSR architecture, one message symbol per clock, highest degree first.
// Optional build macro ENCODER_SELF_CHECK_EN adds a 15-cycle syndrome check
// of the assembled codeword and the checkError output.
module rs_encoder_serial #(
    parameter int SYM_W = 4,
    parameter int N     = 15,
    parameter int K     = 9
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [SYM_W*K-1:0] messageIn,
    input  logic               encodeMessage,
    output logic               encoderBusy,
    output logic               codewordValid,
    output logic [SYM_W*N-1:0] codewordOut
`ifdef ENCODER_SELF_CHECK_EN
    ,
    output logic               checkError
`endif
);

    // Only the RS(15,9) / GF(16) configuration is implemented.
    if (SYM_W != 4 || N != 15 || K != 9) begin : g_bad_cfg
        $error("rs_encoder_serial supports only SYM_W=4, N=15, K=9");
    end

    // Generator coefficients g5..g0 packed as nibbles; g6 = 1 is implicit.
    localparam logic [23:0] GEN = 24'h793CAC;

    // Multiply in GF(16): shift-and-add with reduction by x^4 = x + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] t;
        r = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ t;
            t = {t[2:0], 1'b0} ^ {2'b00, t[3], t[3]};
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
`ifdef ENCODER_SELF_CHECK_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [35:0] shadow;
    logic [23:0] par, par_nxt;
    logic [3:0]  cnt;
    logic [3:0]  sym, fb;

    // Pick message symbol (8-cnt) from the shadow register, build the LFSR update.
    always_comb begin
        sym = 4'h0;
        for (int j = 0; j < 9; j++) begin
            if (cnt == 4'(8 - j)) sym = shadow[4*j +: 4];
        end
        fb = sym ^ par[23:20];
        par_nxt[3:0] = gf_mul(GEN[3:0], fb);
        for (int n = 1; n < 6; n++) begin
            par_nxt[4*n +: 4] = par[4*(n-1) +: 4] ^ gf_mul(GEN[4*n +: 4], fb);
        end
    end

`ifdef ENCODER_SELF_CHECK_EN
    // alpha^1..alpha^6 packed as nibbles, alpha^1 in the low nibble.
    localparam logic [23:0] ALPHA = 24'hC63842;

    logic [23:0] syn, syn_nxt;
    logic [59:0] cw_cat;
    logic [3:0]  csym;

    // Horner step for all six syndromes, codeword symbol 14 fed first.
    always_comb begin
        cw_cat = {shadow, par};
        csym   = 4'h0;
        for (int j = 0; j < 15; j++) begin
            if (cnt == 4'(14 - j)) csym = cw_cat[4*j +: 4];
        end
        for (int i = 0; i < 6; i++) begin
            syn_nxt[4*i +: 4] = gf_mul(syn[4*i +: 4], ALPHA[4*i +: 4]) ^ csym;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; starts are only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (encodeMessage) state_nxt = ENCODE;
`ifdef ENCODER_SELF_CHECK_EN
            ENCODE: if (cnt == 4'd8) state_nxt = CHECK;
            CHECK:  if (cnt == 4'd14) state_nxt = DONE;
`else
            ENCODE: if (cnt == 4'd8) state_nxt = DONE;
`endif
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign encoderBusy = (state != IDLE);

    // Datapath: latch message, run the LFSR, publish the codeword in DONE.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shadow        <= '0;
            par           <= '0;
            cnt           <= '0;
            codewordOut   <= '0;
            codewordValid <= 1'b0;
`ifdef ENCODER_SELF_CHECK_EN
            syn           <= '0;
            checkError    <= 1'b0;
`endif
        end else begin
            codewordValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (encodeMessage) begin
                        shadow <= messageIn;
                        par    <= '0;
                        cnt    <= '0;
                    end
                end
                ENCODE: begin
                    par <= par_nxt;
                    cnt <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
`ifdef ENCODER_SELF_CHECK_EN
                    if (cnt == 4'd8) syn <= '0;
`endif
                end
`ifdef ENCODER_SELF_CHECK_EN
                CHECK: begin
                    syn <= syn_nxt;
                    cnt <= cnt + 4'd1;
                end
`endif
                DONE: begin
                    codewordOut   <= {shadow, par};
                    codewordValid <= 1'b1;
`ifdef ENCODER_SELF_CHECK_EN
                    checkError    <= |syn;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_serial.sv
// Bench for rs_encoder_serial: scoreboard of expected codewords and valid
// cycles, reference codewords from polynomial long division over GF(16).
module tb_rs_encoder_serial;

`ifdef ENCODER_SELF_CHECK_EN
    localparam int LAT = 26;
`else
    localparam int LAT = 11;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [35:0] messageIn = '0;
    logic        encodeMessage = 1'b0;
    logic        encoderBusy;
    logic        codewordValid;
    logic [59:0] codewordOut;
`ifdef ENCODER_SELF_CHECK_EN
    logic        checkError;
`endif

    rs_encoder_serial dut (
        .clk(clk),
        .rstN(rstN),
        .messageIn(messageIn),
        .encodeMessage(encodeMessage),
        .encoderBusy(encoderBusy),
        .codewordValid(codewordValid),
        .codewordOut(codewordOut)
`ifdef ENCODER_SELF_CHECK_EN
        ,
        .checkError(checkError)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [59:0] cw;
        logic        ck;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // GF(16) log/antilog tables
    logic [3:0] gexp[15];
    int         glog[16];

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Reference: remainder of m(x)*x^6 divided by g(x), by long division.
    function automatic logic [59:0] ref_cw(input logic [35:0] m);
        logic [3:0]  r[15];
        logic [3:0]  g[7];
        logic [3:0]  q;
        logic [59:0] res;
        g = '{4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7, 4'h1};
        for (int i = 0; i < 15; i++) r[i] = 4'h0;
        for (int j = 0; j < 9; j++) r[j+6] = m[4*j +: 4];
        for (int d = 14; d >= 6; d--) begin
            q = r[d];
            for (int j = 0; j <= 6; j++) r[d-6+j] = r[d-6+j] ^ gmul(q, g[j]);
        end
        res = '0;
        for (int j = 0; j < 9; j++) res[4*(j+6) +: 4] = m[4*j +: 4];
        for (int i = 0; i < 6; i++) res[4*i +: 4] = r[i];
        return res;
    endfunction

    // Output monitor: every valid must match the oldest scoreboard entry.
    always @(posedge clk) begin
        #1;
        if (rstN && codewordValid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", codewordValid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("codeword", codewordOut, e.cw);
                check("latency", cyc, e.at);
`ifdef ENCODER_SELF_CHECK_EN
                check("checkError", checkError, e.ck);
`endif
            end
        end
    end

    // Called at a negedge: the next posedge samples the start.
    task automatic start_enc(input logic [35:0] m, input logic [59:0] cw, input logic ck);
        messageIn = m;
        encodeMessage = 1'b1;
        sb.push_back('{cw, ck, cyc + LAT});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_one(input logic [35:0] m, input logic [59:0] cw, input logic ck);
        @(negedge clk);
        start_enc(m, cw, ck);
        @(negedge clk);
        encodeMessage = 1'b0;
        wait_drain(LAT + 5);
        @(negedge clk);
    endtask

    logic [35:0] msg_a, msg_b, m;
    int          c0;

    initial begin
        begin
            logic [3:0] v;
            v = 4'h1;
            for (int i = 0; i < 15; i++) begin
                gexp[i] = v;
                glog[v] = i;
                v = {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
            end
            glog[0] = 0;
        end

        // reset values
        repeat (3) @(negedge clk);
        check("rst_busy", encoderBusy, 1'b0);
        check("rst_valid", codewordValid, 1'b0);
        check("rst_cw", codewordOut, 60'h0);
`ifdef ENCODER_SELF_CHECK_EN
        check("rst_checkError", checkError, 1'b0);
`endif
        rstN = 1'b1;

        // all-zero message, busy profile across the whole latency
        @(negedge clk);
        start_enc(36'h0, 60'h0, 1'b0);
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) encodeMessage = 1'b0;
            check("busy_profile", encoderBusy, i < LAT - 1);
        end
        wait_drain(5);

        // single-symbol messages: codeword is g(x) and alpha*g(x)
        run_one(36'h000000001, 60'h000000001793CAC, 1'b0);
        run_one(36'h000000002, 60'h000000002E16B7B, 1'b0);

        // ignored starts mid-encode and in DONE, then back-to-back start
        msg_a = 36'h123456789;
        msg_b = 36'hFEDCBA987;
        @(negedge clk);
        c0 = cyc;
        start_enc(msg_a, ref_cw(msg_a), 1'b0);
        @(negedge clk);
        encodeMessage = 1'b0;
        messageIn = msg_b;
        for (int i = 2; i < LAT; i++) begin
            @(negedge clk);
            encodeMessage = (i == 3 || i == 7 || i == LAT - 1);
        end
        @(negedge clk);
        check("b2b_valid_seen", codewordValid, 1'b1);
        start_enc(msg_b, ref_cw(msg_b), 1'b0);
        @(negedge clk);
        encodeMessage = 1'b0;
        wait_drain(LAT + 5);

        // start held high re-triggers in every IDLE cycle
        @(negedge clk);
        c0 = cyc;
        m = 36'h0A5A5A5A5;
        start_enc(m, ref_cw(m), 1'b0);
        sb.push_back('{ref_cw(m), 1'b0, c0 + 2 * LAT});
        repeat (LAT + 1) @(negedge clk);
        encodeMessage = 1'b0;
        wait_drain(2 * LAT + 5);

        // reset in the middle of encoding aborts with no valid
        @(negedge clk);
        messageIn = 36'h000000001;
        encodeMessage = 1'b1;
        @(negedge clk);
        encodeMessage = 1'b0;
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        #1;
        check("abort_busy", encoderBusy, 1'b0);
        check("abort_valid", codewordValid, 1'b0);
        check("abort_cw", codewordOut, 60'h0);
`ifdef ENCODER_SELF_CHECK_EN
        check("abort_checkError", checkError, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        run_one(36'h000000001, 60'h000000001793CAC, 1'b0);

        // random messages against the division model
        for (int i = 0; i < 6; i++) begin
            m = {4'($urandom_range(15)), 32'($urandom())};
            run_one(m, ref_cw(m), 1'b0);
        end

`ifdef ENCODER_SELF_CHECK_EN
        // corrupt a parity bit so the assembled word is not a codeword
        @(negedge clk);
        start_enc(36'h0, 60'h1, 1'b1);
        @(negedge clk);
        encodeMessage = 1'b0;
        repeat (5) @(negedge clk);
        force dut.par = 24'h000001;
        wait_drain(LAT + 5);
        release dut.par;
        run_one(36'h000000002, 60'h000000002E16B7B, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
